// File: rtl/intt_pkg.sv
// Shared constants and helpers for the INTT butterfly datapath: default modulus,
// Barrett constant derivation and the modular halving used to fold n^-1 scaling.
package intt_pkg;

    localparam int INTT_Q = 257;
    localparam int INTT_N = $clog2(INTT_Q);

    // floor(2^(2n) / q): the Barrett constant for a 2n-bit dividend.
    function automatic int barrett_mu(input int q, input int n);
        return (1 << (2 * n)) / q;
    endfunction

    localparam int INTT_MU = barrett_mu(INTT_Q, INTT_N);

    // x * 2^-1 mod q for x in [0, q-1]; q odd so (x + q) is even when x is odd.
    function automatic int half_mod(input int x, input int q);
        return (x % 2 == 0) ? (x / 2) : ((x + q) / 2);
    endfunction

endpackage

// File: rtl/intt_modred_barrett.sv
// Combinational Barrett reduction of a 2N-bit product to [0, Q-1].
// The quotient estimate is at most one low, so one conditional subtract suffices.
module intt_modred_barrett
    import intt_pkg::*;
#(
    parameter int Q = INTT_Q,
    parameter int N = $clog2(Q)
) (
    input  logic [2*N-1:0] x,
    output logic [N-1:0]   r
);

    localparam int            W  = 3 * N + 1;
    localparam logic [N:0]    MU = (N+1)'(barrett_mu(Q, N));
    localparam logic [2*N:0]  QW = (2*N+1)'(Q);

    logic [W-1:0]  xmu;
    logic [N:0]    qest;
    logic [2*N:0]  qq;
    logic [2*N:0]  rem;

    always_comb begin
        xmu  = W'(x) * W'(MU);
        qest = (N+1)'(xmu >> (2 * N));
        qq   = (2*N+1)'(qest) * QW;
        rem  = {1'b0, x} - qq;
        r    = (rem >= QW) ? N'(rem - QW) : N'(rem);
    end

endmodule

// File: rtl/intt_bfly_pipe.sv
// Three-stage Gentleman-Sande inverse-NTT butterfly: u = a+b, v = (a-b)*w (mod Q).
// Define INTT_BFLY_HALF_EN to multiply non-bypass results by 2^-1 mod Q in the last stage.
module intt_bfly_pipe
    import intt_pkg::*;
#(
    parameter int Q                 = INTT_Q,
    parameter int N                 = $clog2(Q),
    parameter bit BYPASS_EN_DEFAULT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] w,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] u,
    output logic [N-1:0] v,
    output logic         err
);

    localparam logic [N:0] Q_N1 = (N+1)'(Q);

    logic           adv;
    logic           accept;
    logic [N:0]     sum_raw;
    logic [N:0]     diff_raw;
    logic [N-1:0]   sum_red;
    logic [N-1:0]   diff_red;
    logic           in_bad;

    logic           s1_valid_reg;
    logic [N-1:0]   s1_sum_reg;
    logic [N-1:0]   s1_diff_reg;
    logic [N-1:0]   s1_w_reg;
    logic           s1_bypass_reg;

    logic           s2_valid_reg;
    logic [N-1:0]   s2_sum_reg;
    logic [2*N-1:0] s2_prod_reg;
    logic           s2_bypass_reg;

    logic [N-1:0]   red_prod;
    logic [N-1:0]   u_next;
    logic [N-1:0]   v_next;

    logic           out_valid_reg;
    logic [N-1:0]   u_reg;
    logic [N-1:0]   v_reg;
    logic           err_reg;

    // The whole pipe advances as one; a stalled output freezes every stage.
    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = out_valid_reg;
    assign u         = u_reg;
    assign v         = v_reg;
    assign err       = err_reg;

    always_comb begin
        sum_raw  = {1'b0, a} + {1'b0, b};
        sum_red  = (sum_raw >= Q_N1) ? N'(sum_raw - Q_N1) : sum_raw[N-1:0];
        diff_raw = {1'b0, a} - {1'b0, b};
        diff_red = diff_raw[N] ? N'(diff_raw + Q_N1) : diff_raw[N-1:0];
        in_bad   = ({1'b0, a} >= Q_N1) || ({1'b0, b} >= Q_N1) || ({1'b0, w} >= Q_N1);
    end

    intt_modred_barrett #(
        .Q (Q),
        .N (N)
    ) u_modred (
        .x (s2_prod_reg),
        .r (red_prod)
    );

    // Bypass beats park b in the low half of the product register and skip reduction.
    always_comb begin
`ifdef INTT_BFLY_HALF_EN
        u_next = s2_bypass_reg ? s2_sum_reg : N'(half_mod(int'(s2_sum_reg), Q));
        v_next = s2_bypass_reg ? s2_prod_reg[N-1:0] : N'(half_mod(int'(red_prod), Q));
`else
        u_next = s2_sum_reg;
        v_next = s2_bypass_reg ? s2_prod_reg[N-1:0] : red_prod;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sum_reg    <= '0;
            s1_diff_reg   <= '0;
            s1_w_reg      <= '0;
            s1_bypass_reg <= BYPASS_EN_DEFAULT;
            s2_valid_reg  <= 1'b0;
            s2_sum_reg    <= '0;
            s2_prod_reg   <= '0;
            s2_bypass_reg <= BYPASS_EN_DEFAULT;
            out_valid_reg <= 1'b0;
            u_reg         <= '0;
            v_reg         <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (adv) begin
                s1_valid_reg  <= in_valid;
                s1_sum_reg    <= bypass ? a : sum_red;
                s1_diff_reg   <= bypass ? b : diff_red;
                s1_w_reg      <= w;
                s1_bypass_reg <= bypass;

                s2_valid_reg  <= s1_valid_reg;
                s2_sum_reg    <= s1_sum_reg;
                s2_prod_reg   <= s1_bypass_reg ? {{N{1'b0}}, s1_diff_reg}
                                               : (2*N)'(s1_diff_reg) * (2*N)'(s1_w_reg);
                s2_bypass_reg <= s1_bypass_reg;

                out_valid_reg <= s2_valid_reg;
                if (s2_valid_reg) begin
                    u_reg <= u_next;
                    v_reg <= v_next;
                end
            end
            if (accept && in_bad) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_intt_bfly_pipe.sv
// Directed bench for intt_bfly_pipe: vector table, streaming/backpressure runs,
// sticky error and mid-flight reset sequences.
module tb_intt_bfly_pipe;

    localparam int Q = 257;
    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] w;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] u;
    logic [N-1:0] v;
    logic         err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int a;
        int b;
        int w;
        bit byp;
        int eu;
        int ev;
    } vec_t;

    vec_t tbl [8];

    int sa [16];
    int sb [16];
    int sw [16];
    int eu [16];
    int ev [16];

    always #5 clk = ~clk;

    intt_bfly_pipe #(
        .Q                 (Q),
        .N                 (N),
        .BYPASS_EN_DEFAULT (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .w         (w),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .u         (u),
        .v         (v),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fold(input int x);
`ifdef INTT_BFLY_HALF_EN
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
`else
        return x;
`endif
    endfunction

    function automatic int gold_u(input int ga, input int gb);
        return fold((ga + gb) % Q);
    endfunction

    function automatic int gold_v(input int ga, input int gb, input int gw);
        return fold((((ga - gb + Q) % Q) * gw) % Q);
    endfunction

    // One isolated beat: checks latency, results and err.
    task automatic apply_vec(input int idx, input vec_t t, input logic exp_err);
        int lat;
        a = N'(t.a); b = N'(t.b); w = N'(t.w); bypass = t.byp;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bypass = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk($sformatf("vec%0d latency", idx), lat, 3);
        chk($sformatf("vec%0d u", idx), u, t.eu);
        chk($sformatf("vec%0d v", idx), v, t.ev);
        chk($sformatf("vec%0d err", idx), err, exp_err);
        $display("vec%0d a=%0d b=%0d w=%0d byp=%0d -> u=%0d v=%0d lat=%0d",
                 idx, t.a, t.b, t.w, t.byp, u, v, lat);
        step();
    endtask

    // Streams n beats from sa/sb/sw, dropping out_ready for a window; checks order,
    // stability under backpressure and count.
    task automatic stream(input string tag, input int n, input int stall_at, input int stall_len,
                          output int first, output int last);
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        bit acc;
        bit emit;
        first = -1;
        last = -1;
        while ((sent < n || recv < n) && cyc < 100) begin
            in_valid = (sent < n);
            if (sent < n) begin
                a = N'(sa[sent]); b = N'(sb[sent]); w = N'(sw[sent]);
            end
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (out_valid) begin
                if (recv < n) begin
                    chk($sformatf("%s beat%0d u", tag, recv), u, eu[recv]);
                    chk($sformatf("%s beat%0d v", tag, recv), v, ev[recv]);
                end else begin
                    chk($sformatf("%s extra beat", tag), 1, 0);
                end
                if (!out_ready) chk($sformatf("%s in_ready stalled", tag), in_ready, 0);
            end
            if (emit) begin
                $display("%s cyc=%0d out beat%0d u=%0d v=%0d", tag, cyc, recv, u, v);
                if (first < 0) first = cyc;
                last = cyc;
                recv++;
            end
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("%s beats received", tag), recv, n);
    endtask

    initial begin
        int first;
        int last;
        int stale;

        // Hand-computed vectors, Q = 257.
`ifdef INTT_BFLY_HALF_EN
        tbl[0] = '{10,  3,   2,   1'b0, 135, 7};
        tbl[1] = '{3,   10,  2,   1'b0, 135, 250};
        tbl[2] = '{256, 256, 5,   1'b0, 256, 0};
        tbl[3] = '{0,   256, 256, 1'b0, 128, 128};
        tbl[4] = '{100, 200, 7,   1'b1, 100, 200};
        tbl[5] = '{128, 129, 200, 1'b0, 0,   157};
        tbl[6] = '{256, 0,   256, 1'b0, 128, 129};
        tbl[7] = '{1,   1,   1,   1'b0, 1,   0};
`else
        tbl[0] = '{10,  3,   2,   1'b0, 13,  14};
        tbl[1] = '{3,   10,  2,   1'b0, 13,  243};
        tbl[2] = '{256, 256, 5,   1'b0, 255, 0};
        tbl[3] = '{0,   256, 256, 1'b0, 256, 256};
        tbl[4] = '{100, 200, 7,   1'b1, 100, 200};
        tbl[5] = '{128, 129, 200, 1'b0, 0,   57};
        tbl[6] = '{256, 0,   256, 1'b0, 256, 1};
        tbl[7] = '{1,   1,   1,   1'b0, 2,   0};
`endif

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        bypass = 1'b0;
        a = '0; b = '0; w = '0;
        step();
        step();
        chk("reset out_valid", out_valid, 0);
        chk("reset u", u, 0);
        chk("reset v", v, 0);
        chk("reset err", err, 0);
        chk("reset in_ready", in_ready, 1);
        $display("reset out_valid=%0d u=%0d v=%0d err=%0d", out_valid, u, v, err);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) apply_vec(i, tbl[i], 1'b0);

        // Back-to-back beats at full throughput.
        for (int i = 0; i < 8; i++) begin
            sa[i] = (i * 37 + 5) % Q;
            sb[i] = (i * 91 + 200) % Q;
            sw[i] = (i * 53 + 11) % Q;
            eu[i] = gold_u(sa[i], sb[i]);
            ev[i] = gold_v(sa[i], sb[i], sw[i]);
        end
        stream("b2b", 8, 1000, 0, first, last);
        chk("b2b first latency", first, 3);
        chk("b2b consecutive", last - first, 7);

        // Full pipe held by backpressure for five cycles.
        for (int i = 0; i < 6; i++) begin
            sa[i] = (i * 71 + 250) % Q;
            sb[i] = (i * 19 + 3) % Q;
            sw[i] = (i * 113 + 256) % Q;
            eu[i] = gold_u(sa[i], sb[i]);
            ev[i] = gold_v(sa[i], sb[i], sw[i]);
        end
        stream("stall", 6, 2, 6, first, last);
        stale = 0;
        repeat (4) begin
            step();
            if (out_valid) stale++;
        end
        chk("stall no duplicate", stale, 0);

        // Out-of-range bypass beat sets sticky err.
        a = N'(300); b = '0; w = '0; bypass = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bypass = 1'b0;
        chk("oor err set", err, 1);
        step();
        step();
        chk("oor bypass out_valid", out_valid, 1);
        chk("oor bypass u", u, 300);
        chk("oor bypass v", v, 0);
        $display("oor a=300 byp=1 -> u=%0d v=%0d err=%0d", u, v, err);
        step();
        apply_vec(8, tbl[0], 1'b1);
        chk("err sticky", err, 1);
        rst_n = 1'b0;
        #1;
        chk("err cleared by reset", err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = N'(i + 20); b = N'(i + 1); w = N'(3);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("inflight pipe full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset u", u, 0);
        chk("midreset v", v, 0);
        $display("midreset out_valid=%0d u=%0d v=%0d", out_valid, u, v);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            step();
            if (out_valid) stale++;
        end
        chk("no stale after reset", stale, 0);
        apply_vec(9, tbl[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/intt_bfly_pipe.md
Name: intt_bfly_pipe

Overview:
- Pipelined, parametrised Gentleman-Sande inverse-NTT butterfly for the INTT datapath.
- Per accepted operand pair (a, b) with twiddle w it produces u = (a + b) mod Q and v = ((a − b) mod Q)·w mod Q.
- Fixed 3-cycle latency with valid/ready handshakes on both sides.
- Used by the INTT stage controller in place of two combinational add/sub-multiply elements.

Parameters:
- Q, 257, prime modulus; all operands and results lie in [0, Q−1].
- N, $clog2(Q), operand/result width in bits.
- BYPASS_EN_DEFAULT, 0, reset value of the internal bypass latch (1 = pass-through).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  N  upper operand
- b  in  N  lower operand
- w  in  N  twiddle factor (inverse root power)
- bypass  in  1  sampled with the beat; 1 = u=a, v=b unchanged
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- u  out  N  sum output
- v  out  N  twiddled difference output
- err  out  1  sticky: some accepted beat had a≥Q, b≥Q or w≥Q

Behaviour:
- Reset (asynchronous on rst_n low): all stage valid bits 0, out_valid=0, u=v=0, err=0. in_ready may be 1 while in reset deasserted; no beat is accepted while rst_n=0.
- Beat transfer: in on in_valid&in_ready; out on out_valid&out_ready.
- Pipeline S1→S2→S3, one valid bit each:
  - S1: sum and diff, each reduced to [0, Q−1]. Sum: s = a+b (N+1 bits), subtract Q if s≥Q. Diff: d = a−b, add Q if negative. Register the reduced sum, the reduced diff, w and bypass.
  - S2: full N×N product p = d·w (2N bits) registered; sum and bypass carried along.
  - S3: p mod Q via Barrett (single conditional final subtract), registered into u/v.
  - bypass beats: u=a, v=b carried unchanged; no reduction applied.
- Latency: an accepted beat appears on out_valid exactly 3 cycles later when out_ready stays 1.
- Throughput: 1 beat/cycle when out_ready=1.
- Stall: adv = !out_valid | out_ready; all stages shift only when adv=1; in_ready = adv. No bubble collapsing; the whole pipe freezes on backpressure, so u/v hold stable while out_valid & !out_ready.
- Same-cycle accept and emit both happen (full throughput).
- Out-of-range operands (≥Q) are still processed with the same reduction logic (result unspecified but < 2^N) and set err on acceptance. err clears only on reset.
- Boundaries, Q=257:
  - a=b=256 → u=255, v=0.
  - a=0, b=256, w=256 → v = 1·256 mod 257 = 256.
- Reset mid-operation discards all in-flight beats.

Optional Feature:
- Macro: INTT_BFLY_HALF_EN.
- Defined: non-bypass results are multiplied by 2^−1 mod Q in S3, combinationally and with no added latency. x even → x/2; x odd → (x+Q)/2. Applied to both u and v, so log2(n) stages fold the final n^−1 scaling.
- Undefined: no halving; S3 logic is absent.

Decomposition:
- Package intt_pkg: Q, N, Barrett constant MU = floor(2^(2N)/Q), and the half-modulus helper function.
- Sub-module intt_modred_barrett (input 2N bits, output N bits, combinational), instantiated in S3.
- Add/sub reduction stays inline.

Test Plan:
- Reset, then a=10, b=3, w=2, out_ready=1 → 3 cycles later u=13, v=14, err=0.
- a=3, b=10, w=2 → u=13, v=243; with INTT_BFLY_HALF_EN → u=135, v=250.
- 8 back-to-back beats, out_ready=1 → 8 consecutive out_valid cycles, order preserved, results match the golden model.
- out_ready=0 for 5 cycles with a full pipe → in_ready=0, u/v stable, no loss or duplication after release.
- bypass=1, a=100, b=200 → u=100, v=200; a=300 (Q=257) → err=1 and stays 1 until rst_n pulse.
- rst_n asserted with 3 beats in flight → out_valid=0 and u=v=0 immediately; no stale beat after release.
